fault_campaign_ctrl: RTL
========================

Name: fault_campaign_ctrl

Overview:
- Drives the global stuck-at index consumed by every stuck-at fault-injection wrapper in the netlist, one fault site at a time.
- For each site it restarts the stimulus and compares the faulty design's observed outputs against the golden copy's outputs. It then reports, per fault, whether the fault was detected and on which sample.
- It sits in the testbench-side fault-simulation harness, beside the pattern generator, and is the controlling end of the fault-injection interface.

Parameters:
- NFAULTS, 64: total fault sites. Site k is at index FBASE+k; sites are allocated two per bit (stuck0, stuck1).
- FBASE, 0: first fault index.
- IDW, 16: width of the fault index. FBASE+NFAULTS must be < 2^IDW-1.
- OBSW, 32: width of the observed output bus.
- CYCLES, 16: valid observation samples per fault; must be ≥1.
- EARLY_STOP, 1: when 1, a fault ends at its first mismatch; when 0, all CYCLES samples always run.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a campaign when idle
- abort  input  1  ends the campaign after the current fault is reported
- stuck_id  output  IDW  active fault index; all-ones means no fault injected
- pattern_restart  output  1  one-cycle pulse; stimulus generator rewinds
- obs_valid  input  1  golden/faulty samples are valid this cycle
- obs_golden  input  OBSW  fault-free output sample
- obs_faulty  input  OBSW  faulted-design output sample
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts the result
- res_id  output  IDW  fault index of the result
- res_detected  output  1  1 = at least one mismatch seen
- res_sample  output  8  sample number (0-based) of the first mismatch; 0 if undetected
- busy  output  1  campaign in progress
- done  output  1  level; high from campaign end until the next start
- detected_cnt  output  IDW  detected faults in the current campaign

Behaviour:
- Reset: state IDLE; stuck_id=all-ones; pattern_restart, res_valid, busy, done = 0; detected_cnt = 0; res_* = 0; internal abort flag cleared. Reset mid-campaign abandons it immediately; no result is emitted.
- IDLE:
  - start=1: cur=FBASE, detected_cnt=0, done=0, busy=1, go to ARM.
  - start is ignored in every other state.
- ARM, 1 cycle: stuck_id=cur; pattern_restart=1; sample counter=0; mismatch flag cleared. Go to RUN. stuck_id changes only on the ARM edge, so the injection is stable before the restart takes effect.
- RUN:
  - Only cycles with obs_valid=1 count.
  - On each valid sample: if obs_golden != obs_faulty (full OBSW compare) and no earlier mismatch, latch mismatch=1 and first_sample=counter. Then counter++.
  - Leave RUN when counter reaches CYCLES, or on the first mismatch when EARLY_STOP=1; the mismatching sample itself is still recorded.
  - Exit to REPORT the cycle after the terminating sample.
  - obs_valid during ARM, REPORT or IDLE is ignored.
- REPORT:
  - res_valid=1; res_id=cur; res_detected=mismatch; res_sample=first_sample (counter saturates at 255 for the field).
  - res_* stay stable while res_valid=1 and res_ready=0. The transfer happens on the cycle where res_valid and res_ready are both 1.
  - On transfer, detected_cnt increments if detected. Then:
    - go to DONE if cur==FBASE+NFAULTS-1 or the abort flag is set;
    - otherwise cur++ and go to ARM.
  - res_ready may be held high permanently, giving one result every CYCLES+2 valid-dense cycles.
- Abort: abort=1 in any busy state sets a sticky flag. The in-flight fault completes RUN and REPORT normally. abort in IDLE or DONE has no effect.
- DONE: stuck_id=all-ones; busy=0; done=1; wait for start, which behaves as in IDLE.
- stuck_id is all-ones in IDLE, DONE and reset, so the design runs fault-free outside a campaign.
- pattern_restart is asserted only in ARM, exactly one cycle per fault.

Test Plan:
- NFAULTS=4, FBASE=10, CYCLES=4, obs_valid=1 always, golden==faulty, res_ready=1: start -> stuck_id walks 10,11,12,13; 4 results all res_detected=0; 4 pattern_restart pulses; done=1, detected_cnt=0, stuck_id=0xFFFF.
- Same, with a mismatch on sample 2 only while stuck_id=11, EARLY_STOP=1 -> result id=11, detected=1, sample=2; RUN for id 11 lasts 3 valid samples; detected_cnt=1 at end.
- EARLY_STOP=0, mismatches on samples 1 and 3 for id 10 -> res_sample=1; RUN still consumes all 4 samples.
- res_ready held 0 for 5 cycles in REPORT -> res_* stable; stuck_id unchanged; no ARM until the handshake completes.
- obs_valid toggling 1,0,0,1,… -> only valid cycles counted; each fault needs exactly CYCLES valid samples.
- abort during RUN of id 11 -> result for 11 emitted, then DONE, no ARM for 12. Separately, rst mid-RUN -> next cycle IDLE, stuck_id=all-ones, res_valid=0, busy=0; a second start during busy is ignored.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer: walks the global fault index one site at a time,
// compares faulty against golden samples per site and hands out one result per fault.
module fault_campaign_ctrl #(
   parameter int NFAULTS    = 64,
   parameter int FBASE      = 0,
   parameter int IDW        = 16,
   parameter int OBSW       = 32,
   parameter int CYCLES     = 16,
   parameter int EARLY_STOP = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_abort,
   output logic [IDW-1:0]  o_stuck_id,
   output logic            o_pattern_restart,
   input  logic            i_obs_valid,
   input  logic [OBSW-1:0] i_obs_golden,
   input  logic [OBSW-1:0] i_obs_faulty,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [IDW-1:0]  o_res_id,
   output logic            o_res_detected,
   output logic [7:0]      o_res_sample,
   output logic            o_busy,
   output logic            o_done,
   output logic [IDW-1:0]  o_detected_cnt,
   output logic [2:0]      o_dbg_state
);

   localparam int CNTW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
   localparam logic [IDW-1:0]  FIRST_ID = IDW'(FBASE);
   localparam logic [IDW-1:0]  LAST_ID  = IDW'(FBASE + NFAULTS - 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARM    = 3'd1,
      S_RUN    = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          r_state,    w_state;
   logic [IDW-1:0]  r_cur,      w_cur;
   logic [CNTW-1:0] r_cnt,      w_cnt;
   logic            r_mismatch, w_mismatch;
   logic [7:0]      r_first,    w_first;
   logic            r_abort,    w_abort;
   logic [IDW-1:0]  r_det_cnt,  w_det_cnt;

   logic            w_hit;
   logic            w_new_hit;
   logic            w_busy_st;
   logic            w_abort_any;
   logic [31:0]     w_cnt_ext;
   logic [7:0]      w_first_sat;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cur      <= '0;
         r_cnt      <= '0;
         r_mismatch <= 1'b0;
         r_first    <= '0;
         r_abort    <= 1'b0;
         r_det_cnt  <= '0;
      end else begin
         r_state    <= w_state;
         r_cur      <= w_cur;
         r_cnt      <= w_cnt;
         r_mismatch <= w_mismatch;
         r_first    <= w_first;
         r_abort    <= w_abort;
         r_det_cnt  <= w_det_cnt;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_cur       = r_cur;
      w_cnt       = r_cnt;
      w_mismatch  = r_mismatch;
      w_first     = r_first;
      w_abort     = r_abort;
      w_det_cnt   = r_det_cnt;
      w_hit       = (i_obs_golden != i_obs_faulty);
      w_new_hit   = w_hit && !r_mismatch;
      w_busy_st   = (r_state == S_ARM) || (r_state == S_RUN) || (r_state == S_REPORT);
      w_abort_any = r_abort || i_abort;
      w_cnt_ext   = 32'(r_cnt);
      // The reported sample field is 8 bits wide; longer runs saturate.
      w_first_sat = (w_cnt_ext > 32'd255) ? 8'hFF : w_cnt_ext[7:0];

      if (w_busy_st && i_abort) begin
         w_abort = 1'b1;
      end

      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_cur     = FIRST_ID;
               w_det_cnt = '0;
               w_abort   = 1'b0;
               w_state   = S_ARM;
            end
         end
         S_ARM: begin
            w_cnt      = '0;
            w_mismatch = 1'b0;
            w_first    = '0;
            w_state    = S_RUN;
         end
         S_RUN: begin
            if (i_obs_valid) begin
               if (w_new_hit) begin
                  w_mismatch = 1'b1;
                  w_first    = w_first_sat;
               end
               w_cnt = r_cnt + CNTW'(1);
               if ((r_cnt == CNT_LAST) || ((EARLY_STOP != 0) && w_new_hit)) begin
                  w_state = S_REPORT;
               end
            end
         end
         S_REPORT: begin
            // Transfer completes on valid && ready; fields stay frozen until then.
            if (i_res_ready) begin
               if (r_mismatch) begin
                  w_det_cnt = r_det_cnt + IDW'(1);
               end
               if ((r_cur == LAST_ID) || w_abort_any) begin
                  w_state = S_DONE;
               end else begin
                  w_cur   = r_cur + IDW'(1);
                  w_state = S_ARM;
               end
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Outside a campaign the index is all-ones so every wrapper stays fault-free.
   assign o_stuck_id        = w_busy_st ? r_cur : '1;
   assign o_pattern_restart = (r_state == S_ARM);
   assign o_res_valid       = (r_state == S_REPORT);
   assign o_res_id          = o_res_valid ? r_cur : '0;
   assign o_res_detected    = o_res_valid && r_mismatch;
   assign o_res_sample      = o_res_valid ? r_first : '0;
   assign o_busy            = w_busy_st;
   assign o_done            = (r_state == S_DONE);
   assign o_detected_cnt    = r_det_cnt;
   assign o_dbg_state       = r_state;

endmodule
